// File: rtl/border_packet_framer.sv
// border_packet_framer
//   Store-and-forward packetiser between the chain-code encoder and the UART
//   transmitter. It latches the object start point, buffers the chain-code
//   stream, latches area/perimeter/error when the encoder finishes, and then
//   emits one framed, tagged, checksummed byte packet, one byte per UART
//   handshake.
//
//   Packet: SOF 00 | X {1,nib}*NC | Y {2,nib}*NC | codes {01010,code}*n |
//           area {6,nib}*NA | perim {9,nib}*NP | status {B,00,ovf,err} |
//           cs hi {C,cs[7:4]} | cs lo {D,cs[3:0]} | EOF FF
//   cs is the XOR of every byte from the first X byte through the status byte.
//   Tags keep 0x00 and 0xFF exclusive to SOF and EOF.
//
// Ports
//   Clk, reset    clock, asynchronous active-high reset
//   start_in      pulse: new object, latch start_x/start_y (IDLE only)
//   start_x/y     object start column/row
//   code_valid    chain code present this cycle
//   code          chain code 0..7
//   code_ready    high while collecting codes
//   done_in       pulse: encoder finished, latch area/perimeter/enc_error
//   area          object area
//   perimeter     object perimeter
//   enc_error     encoder error flag
//   tx_start      one-cycle pulse, tx_data holds the byte to send
//   tx_data       byte to UART
//   tx_done       pulse: UART finished the current byte
//   busy          framer is not idle
//   overflow      sticky per packet: at least one code was dropped
//   code_count    codes stored for the current object
//   pkt_sent      one-cycle pulse after the EOF byte completes
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE    | waiting for start_in; done_in/code_valid ignored
// S_COLLECT | buffering codes until done_in
// S_SEND    | present the current packet byte and pulse tx_start
// S_WAIT    | wait for tx_done, then advance to the next byte or finish

module border_packet_framer #(
  parameter int COORD_W   = 6,
  parameter int AREA_W    = 12,
  parameter int PERIM_W   = 8,
  parameter int MAX_CODES = 256,
  parameter int CNT_W     = $clog2(MAX_CODES + 1)
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               start_in,
  input  logic [COORD_W-1:0] start_x,
  input  logic [COORD_W-1:0] start_y,
  input  logic               code_valid,
  input  logic [2:0]         code,
  output logic               code_ready,
  input  logic               done_in,
  input  logic [AREA_W-1:0]  area,
  input  logic [PERIM_W-1:0] perimeter,
  input  logic               enc_error,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_done,
  output logic               busy,
  output logic               overflow,
  output logic [CNT_W-1:0]   code_count,
  output logic               pkt_sent
);

  localparam int NC = (COORD_W + 3) / 4;
  localparam int NA = (AREA_W + 3) / 4;
  localparam int NP = (PERIM_W + 3) / 4;
  localparam int CW = NC * 4;
  localparam int AW = NA * 4;
  localparam int PW = NP * 4;

  localparam int ADDR_W = (MAX_CODES > 1) ? $clog2(MAX_CODES) : 1;
  localparam int NMAX_AP = (NA > NP) ? NA : NP;
  localparam int NMAX = (NC > NMAX_AP) ? NC : NMAX_AP;
  localparam int NIB_W = $clog2(NMAX + 1);
  // One pointer walks both nibble fields and the code buffer.
  localparam int IDX_W = (CNT_W > NIB_W) ? CNT_W : NIB_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_SEND,
    S_WAIT
  } state_t;

  typedef enum logic [3:0] {
    SEC_SOF,
    SEC_X,
    SEC_Y,
    SEC_CODES,
    SEC_AREA,
    SEC_PERIM,
    SEC_STATUS,
    SEC_CS_HI,
    SEC_CS_LO,
    SEC_EOF
  } sec_t;

  state_t           state;
  sec_t             sec;
  sec_t             sec_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;

  logic [CW-1:0]    x_q;
  logic [CW-1:0]    y_q;
  logic [AW-1:0]    area_q;
  logic [PW-1:0]    perim_q;
  logic             err_q;
  logic [7:0]       cs;

  logic [2:0]       code_mem [MAX_CODES];
  logic             code_wr;
  logic             buf_full;

  logic [3:0]       x_nib;
  logic [3:0]       y_nib;
  logic [3:0]       a_nib;
  logic [3:0]       p_nib;
  logic [7:0]       cur_byte;

  assign buf_full = (code_count == CNT_W'(MAX_CODES));
  assign code_wr  = (state == S_COLLECT) && code_valid && !buf_full;

  // Code buffer carries no reset so it can map onto RAM.
  always_ff @(posedge Clk) begin
    if (code_wr) begin
      code_mem[code_count[ADDR_W-1:0]] <= code;
    end
  end

  // Nibble of each field selected by idx, MSB nibble first.
  always_comb begin
    x_nib = 4'h0;
    y_nib = 4'h0;
    a_nib = 4'h0;
    p_nib = 4'h0;
    for (int i = 0; i < NC; i++) begin
      if (idx == IDX_W'(i)) begin
        x_nib = x_q[4*(NC-1-i) +: 4];
        y_nib = y_q[4*(NC-1-i) +: 4];
      end
    end
    for (int i = 0; i < NA; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = area_q[4*(NA-1-i) +: 4];
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (idx == IDX_W'(i)) begin
        p_nib = perim_q[4*(NP-1-i) +: 4];
      end
    end
  end

  always_comb begin
    cur_byte = 8'h00;
    case (sec)
      SEC_SOF:    cur_byte = 8'h00;
      SEC_X:      cur_byte = {4'h1, x_nib};
      SEC_Y:      cur_byte = {4'h2, y_nib};
      SEC_CODES:  cur_byte = {5'b01010, code_mem[idx[ADDR_W-1:0]]};
      SEC_AREA:   cur_byte = {4'h6, a_nib};
      SEC_PERIM:  cur_byte = {4'h9, p_nib};
      SEC_STATUS: cur_byte = {4'hB, 2'b00, overflow, err_q};
      SEC_CS_HI:  cur_byte = {4'hC, cs[7:4]};
      SEC_CS_LO:  cur_byte = {4'hD, cs[3:0]};
      SEC_EOF:    cur_byte = 8'hFF;
      default:    cur_byte = 8'h00;
    endcase
  end

  // Next packet position. The code section is skipped when no code was stored.
  always_comb begin
    sec_nxt = sec;
    idx_nxt = idx + IDX_W'(1);
    case (sec)
      SEC_SOF: begin
        sec_nxt = SEC_X;
        idx_nxt = '0;
      end
      SEC_X: begin
        if (idx == IDX_W'(NC - 1)) begin
          sec_nxt = SEC_Y;
          idx_nxt = '0;
        end
      end
      SEC_Y: begin
        if (idx == IDX_W'(NC - 1)) begin
          sec_nxt = (code_count == '0) ? SEC_AREA : SEC_CODES;
          idx_nxt = '0;
        end
      end
      SEC_CODES: begin
        if ((idx + IDX_W'(1)) == IDX_W'(code_count)) begin
          sec_nxt = SEC_AREA;
          idx_nxt = '0;
        end
      end
      SEC_AREA: begin
        if (idx == IDX_W'(NA - 1)) begin
          sec_nxt = SEC_PERIM;
          idx_nxt = '0;
        end
      end
      SEC_PERIM: begin
        if (idx == IDX_W'(NP - 1)) begin
          sec_nxt = SEC_STATUS;
          idx_nxt = '0;
        end
      end
      SEC_STATUS: begin
        sec_nxt = SEC_CS_HI;
        idx_nxt = '0;
      end
      SEC_CS_HI: begin
        sec_nxt = SEC_CS_LO;
        idx_nxt = '0;
      end
      SEC_CS_LO: begin
        sec_nxt = SEC_EOF;
        idx_nxt = '0;
      end
      default: begin
        sec_nxt = sec;
        idx_nxt = idx;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      sec        <= SEC_SOF;
      idx        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      area_q     <= '0;
      perim_q    <= '0;
      err_q      <= 1'b0;
      cs         <= 8'h00;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      code_ready <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      code_count <= '0;
      pkt_sent   <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      pkt_sent <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_in) begin
            x_q        <= CW'(start_x);
            y_q        <= CW'(start_y);
            code_count <= '0;
            overflow   <= 1'b0;
            cs         <= 8'h00;
            sec        <= SEC_SOF;
            idx        <= '0;
            code_ready <= 1'b1;
            busy       <= 1'b1;
            state      <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          // A code arriving with done_in is still stored: count updates here
          // and the packet is built from the updated count in SEND.
          if (code_valid) begin
            if (buf_full) begin
              overflow <= 1'b1;
            end else begin
              code_count <= code_count + CNT_W'(1);
            end
          end
          if (done_in) begin
            area_q     <= AW'(area);
            perim_q    <= PW'(perimeter);
            err_q      <= enc_error;
            code_ready <= 1'b0;
            state      <= S_SEND;
          end
        end
        S_SEND: begin
          tx_data  <= cur_byte;
          tx_start <= 1'b1;
          if (sec inside {SEC_X, SEC_Y, SEC_CODES, SEC_AREA, SEC_PERIM, SEC_STATUS}) begin
            cs <= cs ^ cur_byte;
          end
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            if (sec == SEC_EOF) begin
              pkt_sent <= 1'b1;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              sec   <= sec_nxt;
              idx   <= idx_nxt;
              state <= S_SEND;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
